// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the period/frequency meter.
// Pure declarations, no logic.
// No flow control.
package freq_meter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DIV,
        BCD,
        DONE
    } state_t;

    localparam int PERIOD_W = 14;
    localparam int QUOT_W   = 17;
    localparam int ITER_CNT = 17;

    localparam int DEF_MAX_PERIOD    = 9999;
    localparam int DEF_MIN_PERIOD    = 10;
    localparam int DEF_DIV_NUMERATOR = 100000;

    // One double-dabble correction on a single BCD digit.
    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to packed BCD converter.
// Latency: W shifts; the first happens on the start edge, done pulses W-1 cycles later.
// No backpressure: a start pulse restarts the conversion at any time.
module bin2bcd_seq
    import freq_meter_pkg::*;
#(
    parameter int W      = 17,
    parameter int DIGITS = 5
) (
    input  logic                clk_alt,
    input  logic                rst_n,
    input  logic                start,
    input  logic [W-1:0]        bin,
    output logic [4*DIGITS-1:0] bcd,
    output logic                done
);

    localparam int CNT_W = $clog2(W + 1);
    localparam int BCD_W = 4 * DIGITS;

    logic [W-1:0]     sh;
    logic [CNT_W-1:0] left;
    logic [BCD_W-1:0] adj;

    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = add3(bcd[4*i +: 4]);
        end
    end

    always_ff @(posedge clk_alt or negedge rst_n) begin
        if (!rst_n) begin
            sh   <= '0;
            left <= '0;
            bcd  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                // The first shift needs no correction since all digits start at zero.
                bcd  <= BCD_W'(bin[W-1]);
                sh   <= {bin[W-2:0], 1'b0};
                left <= CNT_W'(W - 1);
            end else if (left != '0) begin
                bcd  <= BCD_W'({adj, sh[W-1]});
                sh   <= {sh[W-2:0], 1'b0};
                left <= left - CNT_W'(1);
                done <= (left == CNT_W'(1));
            end
        end
    end

endmodule

// File: rtl/freq_meter.sv
// Measures sig_in period in clk_alt ticks and derives freq_x100, both as packed BCD.
// Latency: meas_valid 35 cycles after the capturing rise is detected.
// No backpressure: rises arriving while busy only restart the period counter.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int MAX_PERIOD    = DEF_MAX_PERIOD,
    parameter int MIN_PERIOD    = DEF_MIN_PERIOD,
    parameter int DIV_NUMERATOR = DEF_DIV_NUMERATOR
) (
    input  logic        clk_alt,
    input  logic        rst_n,
    input  logic        sig_in,
    output logic [15:0] period_bcd,
    output logic [19:0] freq_bcd,
    output logic        meas_valid,
    output logic        timeout,
    output logic        busy
);

    localparam logic [PERIOD_W-1:0] MAX_P = PERIOD_W'(MAX_PERIOD);
    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
    localparam logic [QUOT_W-1:0]   NUMER = QUOT_W'(DIV_NUMERATOR);

    state_t              state;
    logic                sync1, sync2, prev, rise;
    logic [PERIOD_W-1:0] cnt, period_r, rem, rem_next;
    logic [QUOT_W-1:0]   quot, quot_next;
    logic [PERIOD_W:0]   trial;
    logic                ge, cnt_sat, sat_pend, bcd_start;
    logic [4:0]          iter;
    logic [15:0]         per_conv;
    logic [19:0]         frq_conv;
    logic                per_done, frq_done;

    assign rise    = sync2 & ~prev;
    assign cnt_sat = (cnt == MAX_P);

    always_ff @(posedge clk_alt or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            prev  <= sync2;
            if (rise) begin
                cnt <= PERIOD_W'(1);
            end else if (!cnt_sat) begin
                cnt <= cnt + PERIOD_W'(1);
            end
        end
    end

    // One restoring-division step per cycle, dividend bits enter from quot's MSB.
    always_comb begin
        trial     = {rem, quot[QUOT_W-1]};
        ge        = (trial >= {1'b0, period_r});
        rem_next  = ge ? PERIOD_W'(trial - {1'b0, period_r}) : trial[PERIOD_W-1:0];
        quot_next = {quot[QUOT_W-2:0], ge};
    end

    // Converters load on the final divide step so the last quotient bit is forwarded.
    assign bcd_start = (state == DIV) && (iter == 5'(ITER_CNT - 1));

    always_ff @(posedge clk_alt or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            period_r   <= '0;
            quot       <= '0;
            rem        <= '0;
            iter       <= '0;
            sat_pend   <= 1'b0;
            period_bcd <= '0;
            freq_bcd   <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b1;
            busy       <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) state <= COUNT;
                end
                COUNT: begin
                    if (rise && cnt >= MIN_P && cnt < MAX_P) begin
                        period_r <= cnt;
                        quot     <= NUMER;
                        rem      <= '0;
                        iter     <= '0;
                        sat_pend <= 1'b0;
                        timeout  <= 1'b0;
                        busy     <= 1'b1;
                        state    <= DIV;
                    end else if (cnt_sat) begin
                        timeout    <= 1'b1;
                        period_bcd <= '0;
                        freq_bcd   <= '0;
                        state      <= IDLE;
                    end
                end
                DIV: begin
                    quot <= quot_next;
                    rem  <= rem_next;
                    iter <= iter + 5'd1;
                    if (cnt_sat) sat_pend <= 1'b1;
                    if (bcd_start) state <= BCD;
                end
                BCD: begin
                    if (cnt_sat) sat_pend <= 1'b1;
                    if (per_done && frq_done) begin
                        busy  <= 1'b0;
                        state <= DONE;
                        if (sat_pend || cnt_sat) begin
                            timeout    <= 1'b1;
                            period_bcd <= '0;
                            freq_bcd   <= '0;
                        end else begin
                            period_bcd <= per_conv;
                            freq_bcd   <= frq_conv;
                            meas_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= sat_pend ? IDLE : COUNT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    bin2bcd_seq #(.W(QUOT_W), .DIGITS(4)) u_per_bcd (
        .clk_alt (clk_alt),
        .rst_n   (rst_n),
        .start   (bcd_start),
        .bin     (QUOT_W'(period_r)),
        .bcd     (per_conv),
        .done    (per_done)
    );

    bin2bcd_seq #(.W(QUOT_W), .DIGITS(5)) u_frq_bcd (
        .clk_alt (clk_alt),
        .rst_n   (rst_n),
        .start   (bcd_start),
        .bin     (quot_next),
        .bcd     (frq_conv),
        .done    (frq_done)
    );

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: square waves of known period, glitches, timeout, reset.
module tb_freq_meter;

    logic        clk_alt = 1'b0;
    logic        rst_n;
    logic        sig_in;
    logic [15:0] period_bcd;
    logic [19:0] freq_bcd;
    logic        meas_valid;
    logic        timeout;
    logic        busy;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int mv_cnt = 0;
    int mv_cyc = 0;
    int busy_cnt = 0;
    int r1 = 0;
    int base = 0;
    logic [15:0] mv_per = '0;
    logic [19:0] mv_frq = '0;

    freq_meter dut (
        .clk_alt    (clk_alt),
        .rst_n      (rst_n),
        .sig_in     (sig_in),
        .period_bcd (period_bcd),
        .freq_bcd   (freq_bcd),
        .meas_valid (meas_valid),
        .timeout    (timeout),
        .busy       (busy)
    );

    always #5 clk_alt = ~clk_alt;

    // Advance one clock and sample 1 ns after the edge; log meas_valid and busy cycles.
    task automatic tick();
        @(posedge clk_alt);
        #1;
        cyc++;
        if (meas_valid) begin
            mv_cnt++;
            mv_cyc = cyc;
            mv_per = period_bcd;
            mv_frq = freq_bcd;
        end
        if (busy) busy_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wave(input int per, input int n);
        for (int p = 0; p < n; p++) begin
            sig_in = 1'b1;
            ticks(per / 2);
            sig_in = 1'b0;
            ticks(per - per / 2);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        sig_in = 1'b0;
        ticks(3);
        chk("rst_period",  32'(period_bcd), 'h0);
        chk("rst_freq",    32'(freq_bcd),   'h0);
        chk("rst_mvalid",  32'(meas_valid), 'h0);
        chk("rst_timeout", 32'(timeout),    'h1);
        chk("rst_busy",    32'(busy),       'h0);
        rst_n = 1'b1;
        ticks(5);

        // 1000-tick wave: first rise arms only, second rise measures.
        mv_cnt = 0;
        wave(1000, 1);
        chk("first_rise_no_meas", mv_cnt, 0);
        chk("timeout_before_meas", 32'(timeout), 'h1);
        r1 = cyc;
        busy_cnt = 0;
        wave(1000, 1);
        chk("p1000_count",   mv_cnt, 1);
        chk("p1000_latency", mv_cyc - r1, 37);
        chk("p1000_period",  32'(mv_per), 'h1000);
        chk("p1000_freq",    32'(mv_frq), 'h00100);
        chk("p1000_timeout", 32'(timeout), 'h0);
        chk("p1000_busy_len", busy_cnt, 34);
        chk("p1000_hold",    32'(period_bcd), 'h1000);

        // 50-tick wave: 35-cycle pipeline finishes before the next rise, all four captured.
        mv_cnt = 0;
        wave(50, 4);
        chk("p50_count",  mv_cnt, 4);
        chk("p50_period", 32'(mv_per), 'h0050);
        chk("p50_freq",   32'(mv_frq), 'h02000);

        // 20-tick wave: every other rise lands while busy and is skipped.
        mv_cnt = 0;
        wave(20, 6);
        chk("p20_count",  mv_cnt, 3);
        chk("p20_period", 32'(mv_per), 'h0020);
        chk("p20_freq",   32'(mv_frq), 'h05000);

        // 333 ticks: 100000/333 = 300.3 truncates to 300.
        mv_cnt = 0;
        wave(333, 2);
        chk("p333_count",  mv_cnt, 2);
        chk("p333_period", 32'(mv_per), 'h0333);
        chk("p333_freq",   32'(mv_frq), 'h00300);

        // 1000-tick stream with a burst of 6-tick pulses after a capture.
        wave(1000, 1);
        mv_cnt = 0;
        sig_in = 1'b1;
        ticks(3);
        sig_in = 1'b0;
        ticks(27);
        for (int g = 0; g < 12; g++) begin
            sig_in = 1'b1;
            ticks(3);
            sig_in = 1'b0;
            ticks(3);
        end
        ticks(898);
        chk("glitch_count",  mv_cnt, 1);
        chk("glitch_period", 32'(period_bcd), 'h1000);
        chk("glitch_freq",   32'(freq_bcd),   'h00100);
        // Next rise measures from the last discarded glitch: 1000-96 = 904.
        mv_cnt = 0;
        base = cyc;
        wave(1000, 1);
        chk("post_glitch_count",  mv_cnt, 1);
        chk("post_glitch_period", 32'(mv_per), 'h0904);
        chk("post_glitch_freq",   32'(mv_frq), 'h00110);

        // Hold low: counter hits 9999 exactly 10001 ticks after the last rise.
        ticks(9001);
        chk("pre_timeout",      32'(timeout),    'h0);
        chk("pre_timeout_hold", 32'(period_bcd), 'h0904);
        tick();
        chk("timeout_set",    32'(timeout),    'h1);
        chk("timeout_period", 32'(period_bcd), 'h0);
        chk("timeout_freq",   32'(freq_bcd),   'h0);

        // Resume with a 200-tick wave: second rise yields a measurement.
        mv_cnt = 0;
        wave(200, 2);
        chk("p200_count",   mv_cnt, 1);
        chk("p200_period",  32'(mv_per), 'h0200);
        chk("p200_freq",    32'(mv_frq), 'h00500);
        chk("p200_timeout", 32'(timeout), 'h0);

        // Reset asserted at D+10 while dividing.
        mv_cnt = 0;
        sig_in = 1'b1;
        ticks(12);
        chk("div_busy", 32'(busy), 'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_period",  32'(period_bcd), 'h0);
        chk("midrst_freq",    32'(freq_bcd),   'h0);
        chk("midrst_mvalid",  32'(meas_valid), 'h0);
        chk("midrst_timeout", 32'(timeout),    'h1);
        chk("midrst_busy",    32'(busy),       'h0);
        ticks(2);
        rst_n = 1'b1;
        ticks(100);
        chk("midrst_no_meas", mv_cnt, 0);
        chk("midrst_period_after", 32'(period_bcd), 'h0);
        sig_in = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
